// File: rtl/phase_sequencer.sv
// Phase sequencer for the multicycle processor: run/stop/single-step control, HLT detection
// and a retired-instruction counter. Define PHASE_SEQ_BREAK_EN to add an instruction-boundary breakpoint.
module phase_sequencer #(
   parameter int NUM_PHASES = 5,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic [15:0]      instruction,
`ifdef PHASE_SEQ_BREAK_EN
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   input  logic [7:0]       pc,
`endif
   output logic [2:0]       phase,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   localparam logic [2:0] LP_LAST = 3'(NUM_PHASES);

   state_t           r_state;
   logic [2:0]       r_phase;
   logic             r_running;
   logic             r_halted;
   logic [CNT_W-1:0] r_retired;
   logic             r_stop_pend;

   state_t           w_state_nxt;
   logic [2:0]       w_phase_nxt;
   logic             w_halted_nxt;
   logic [CNT_W-1:0] w_retired_nxt;
   logic             w_stop_pend_nxt;
   logic             w_is_hlt;
   logic             w_stop_now;
   logic             w_bp_hit;

   assign w_is_hlt   = (instruction[15:14] == 2'b11) && (instruction[7:4] == 4'b1111);
   // A stop arriving on the boundary cycle itself still ends this instruction.
   assign w_stop_now = r_stop_pend | ((r_state == ST_RUN) & stop);
`ifdef PHASE_SEQ_BREAK_EN
   assign w_bp_hit   = (r_state == ST_RUN) && bp_en && (pc == bp_addr);
`else
   assign w_bp_hit   = 1'b0;
`endif

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_phase_nxt     = r_phase;
      w_halted_nxt    = r_halted;
      w_retired_nxt   = r_retired;
      w_stop_pend_nxt = r_stop_pend;
      case (r_state)
         ST_IDLE: begin
            w_phase_nxt = 3'd0;
            if (stop) begin
               w_state_nxt = ST_IDLE;
            end else if (start) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = 3'd1;
            end else if (step) begin
               w_state_nxt = ST_STEP;
               w_phase_nxt = 3'd1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN, ST_STEP: begin
            if ((r_phase == 3'd2) && w_is_hlt) begin
               w_state_nxt     = ST_HALT;
               w_phase_nxt     = 3'd0;
               w_halted_nxt    = 1'b1;
               w_stop_pend_nxt = 1'b0;
            end else if (r_phase == LP_LAST) begin
               w_retired_nxt = r_retired + CNT_W'(1);
               if ((r_state == ST_STEP) || w_stop_now || w_bp_hit) begin
                  w_state_nxt     = ST_IDLE;
                  w_phase_nxt     = 3'd0;
                  w_stop_pend_nxt = 1'b0;
               end else begin
                  w_phase_nxt = 3'd1;
               end
            end else begin
               w_phase_nxt = r_phase + 3'd1;
               if ((r_state == ST_RUN) && stop) begin
                  w_stop_pend_nxt = 1'b1;
               end else begin
                  w_stop_pend_nxt = r_stop_pend;
               end
            end
         end
         ST_HALT: begin
            w_phase_nxt  = 3'd0;
            w_halted_nxt = 1'b1;
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_phase_nxt     = 3'd0;
            w_stop_pend_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_phase     <= 3'd0;
         r_running   <= 1'b0;
         r_halted    <= 1'b0;
         r_retired   <= '0;
         r_stop_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_running   <= (w_phase_nxt != 3'd0);
         r_halted    <= w_halted_nxt;
         r_retired   <= w_retired_nxt;
         r_stop_pend <= w_stop_pend_nxt;
      end
   end

   assign phase   = r_phase;
   assign running = r_running;
   assign halted  = r_halted;
   assign retired = r_retired;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: expected post-edge state is queued with each stimulus
// step and checked on the following falling edge.
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        step = 1'b0;
   logic [15:0] instruction = 16'hC000;
`ifdef PHASE_SEQ_BREAK_EN
   logic        bp_en = 1'b0;
   logic [7:0]  bp_addr = 8'h00;
   logic [7:0]  pc = 8'h00;
`endif
   logic [2:0]  phase;
   logic        running;
   logic        halted;
   logic [15:0] retired;

   typedef struct {
      logic [2:0]  ph;
      logic        hl;
      logic [15:0] ret;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   phase_sequencer #(.NUM_PHASES(5), .CNT_W(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stop(stop),
      .step(step),
      .instruction(instruction),
`ifdef PHASE_SEQ_BREAK_EN
      .bp_en(bp_en),
      .bp_addr(bp_addr),
      .pc(pc),
`endif
      .phase(phase),
      .running(running),
      .halted(halted),
      .retired(retired)
   );

   // pop one expectation per falling edge and compare
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total = total + 1;
         if (phase !== e.ph) begin
            bad = bad + 1;
            $display("FAIL %s phase: got %0d want %0d", e.tag, phase, e.ph);
         end
         total = total + 1;
         if (running !== (e.ph != 3'd0)) begin
            bad = bad + 1;
            $display("FAIL %s running: got %b want %b", e.tag, running, (e.ph != 3'd0));
         end
         total = total + 1;
         if (halted !== e.hl) begin
            bad = bad + 1;
            $display("FAIL %s halted: got %b want %b", e.tag, halted, e.hl);
         end
         total = total + 1;
         if (retired !== e.ret) begin
            bad = bad + 1;
            $display("FAIL %s retired: got %0d want %0d", e.tag, retired, e.ret);
         end
      end
   end

   task automatic cyc(input string tag, input logic [2:0] ph, input logic hl, input logic [15:0] ret);
      exp_t e;
      e.ph = ph; e.hl = hl; e.ret = ret; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0; stop = 1'b0; step = 1'b0; instruction = 16'hC000;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      e.ph = 3'd0; e.hl = 1'b0; e.ret = 16'd0; e.tag = "reset";
      sb.push_back(e);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc("reset_idle", 3'd0, 1'b0, 16'd0);
   endtask

   task automatic test_run_stop();
      do_reset();
      start = 1'b1;
      cyc("run", 3'd1, 1'b0, 16'd0);
      start = 1'b0;
      for (int p = 2; p <= 5; p++) cyc("run", 3'(p), 1'b0, 16'd0);
      cyc("run_wrap", 3'd1, 1'b0, 16'd1);
      cyc("run", 3'd2, 1'b0, 16'd1);
      instruction = 16'h80F0;
      cyc("near_hlt", 3'd3, 1'b0, 16'd1);
      instruction = 16'hC000;
      cyc("run", 3'd4, 1'b0, 16'd1);
      cyc("run", 3'd5, 1'b0, 16'd1);
      cyc("run_wrap2", 3'd1, 1'b0, 16'd2);
      cyc("run", 3'd2, 1'b0, 16'd2);
      stop = 1'b1;
      cyc("stop", 3'd3, 1'b0, 16'd2);
      stop = 1'b0;
      cyc("stop", 3'd4, 1'b0, 16'd2);
      cyc("stop", 3'd5, 1'b0, 16'd2);
      cyc("stop_idle", 3'd0, 1'b0, 16'd3);
      cyc("stop_idle", 3'd0, 1'b0, 16'd3);
   endtask

   task automatic test_step();
      do_reset();
      step = 1'b1;
      cyc("step", 3'd1, 1'b0, 16'd0);
      step = 1'b0;
      cyc("step", 3'd2, 1'b0, 16'd0);
      cyc("step", 3'd3, 1'b0, 16'd0);
      step = 1'b1;
      cyc("step_ignored", 3'd4, 1'b0, 16'd0);
      step = 1'b0;
      cyc("step", 3'd5, 1'b0, 16'd0);
      cyc("step_done", 3'd0, 1'b0, 16'd1);
      cyc("step_done", 3'd0, 1'b0, 16'd1);
   endtask

   task automatic test_idle_priority();
      do_reset();
      start = 1'b1; stop = 1'b1;
      cyc("start_stop", 3'd0, 1'b0, 16'd0);
      step = 1'b1;
      cyc("all_three", 3'd0, 1'b0, 16'd0);
      start = 1'b0; stop = 1'b0; step = 1'b0;
      cyc("idle", 3'd0, 1'b0, 16'd0);
   endtask

   task automatic test_hlt();
      do_reset();
      start = 1'b1;
      cyc("hlt_pre", 3'd1, 1'b0, 16'd0);
      start = 1'b0;
      for (int p = 2; p <= 5; p++) cyc("hlt_pre", 3'(p), 1'b0, 16'd0);
      cyc("hlt_pre", 3'd1, 1'b0, 16'd1);
      instruction = 16'hC0F0;
      cyc("hlt", 3'd2, 1'b0, 16'd1);
      cyc("hlt_halt", 3'd0, 1'b1, 16'd1);
      start = 1'b1;
      cyc("halt_start", 3'd0, 1'b1, 16'd1);
      start = 1'b0; step = 1'b1;
      cyc("halt_step", 3'd0, 1'b1, 16'd1);
      step = 1'b0; stop = 1'b1;
      cyc("halt_stop", 3'd0, 1'b1, 16'd1);
      stop = 1'b0;
   endtask

   task automatic test_async_reset();
      exp_t e;
      do_reset();
      start = 1'b1;
      cyc("ar", 3'd1, 1'b0, 16'd0);
      start = 1'b0;
      for (int p = 2; p <= 5; p++) cyc("ar", 3'(p), 1'b0, 16'd0);
      cyc("ar", 3'd1, 1'b0, 16'd1);
      cyc("ar", 3'd2, 1'b0, 16'd1);
      cyc("ar", 3'd3, 1'b0, 16'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      e.ph = 3'd0; e.hl = 1'b0; e.ret = 16'd0; e.tag = "async_reset";
      sb.push_back(e);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc("after_reset", 3'd0, 1'b0, 16'd0);
   endtask

`ifdef PHASE_SEQ_BREAK_EN
   task automatic test_breakpoint();
      do_reset();
      pc = 8'h03; bp_addr = 8'h03; bp_en = 1'b0;
      start = 1'b1;
      cyc("bp", 3'd1, 1'b0, 16'd0);
      start = 1'b0;
      for (int p = 2; p <= 4; p++) cyc("bp", 3'(p), 1'b0, 16'd0);
      bp_en = 1'b1;
      cyc("bp", 3'd5, 1'b0, 16'd0);
      cyc("bp_hit", 3'd0, 1'b0, 16'd1);
      bp_en = 1'b0; start = 1'b1;
      cyc("bp_resume", 3'd1, 1'b0, 16'd1);
      start = 1'b0;
      cyc("bp_resume", 3'd2, 1'b0, 16'd1);
   endtask
`endif

   initial begin
      test_reset();
      test_run_stop();
      test_step();
      test_idle_priority();
      test_hlt();
      test_async_reset();
`ifdef PHASE_SEQ_BREAK_EN
      test_breakpoint();
`endif
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
